// File: rtl/audio_sample_reader_pkg.sv
// Shared definitions for the audio sample playback engine.
// Holds the ROM address/sample widths, the default sample-period divider
// (50 MHz / 48 kHz) and the playback FSM state encoding.
package audio_sample_reader_pkg;

  localparam int ADDR_WIDTH         = 18;
  localparam int DATA_WIDTH         = 16;
  localparam int SAMPLE_DIV_DEFAULT = 1042;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_LATCH = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/audio_sample_reader_divider.sv
// sample_rate_divider: free-running sample-period counter.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   clear      : restart the period (count returns to 0)
//   en         : count while playback is active; held at 0 otherwise
//   tick       : high for the last cycle of each SAMPLE_DIV-cycle period
module sample_rate_divider
  import audio_sample_reader_pkg::*;
#(
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear || !en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/audio_sample_reader.sv
// audio_sample_reader: walks the sample ROM from a latched start address to a
// latched end address (inclusive, wrapping through 2^ADDR_WIDTH-1), one
// address per sample period, and offers each sample over valid/ready.
// Ports:
//   clk, reset        : system clock, synchronous active-high reset
//   start, stop       : one-cycle control pulses (stop wins)
//   loop              : latched at start; wrap back to start_addr after end_addr
//   start_addr/end_addr : playback range, latched at start
//   rom_addr/rom_data : ROM read port (one-cycle registered read latency)
//   sample_out/sample_valid/sample_ready : downstream handshake
//   busy              : playback in progress
//   done              : pulse when a non-loop playback finishes
//   underrun          : pulse when a period ends before the sample was taken
module audio_sample_reader
  import audio_sample_reader_pkg::*;
#(
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] start_q;
  logic [ADDR_WIDTH-1:0] end_q;
  logic                  loop_q;
  logic                  accepted;
  logic                  tick;
  logic                  handshake;

  assign busy      = (state != ST_IDLE);
  assign handshake = sample_valid && sample_ready;

  // Any start restarts the period so the first sample period is full length.
  sample_rate_divider #(.SAMPLE_DIV(SAMPLE_DIV)) u_divider (
    .clk  (clk),
    .reset(reset),
    .clear(start),
    .en   (busy),
    .tick (tick)
  );

  // rom_addr doubles as the current playback address: it only changes on
  // entry to ST_ADDR and otherwise holds the last fetched address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      rom_addr     <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
      underrun     <= 1'b0;
      accepted     <= 1'b0;
      start_q      <= '0;
      end_q        <= '0;
      loop_q       <= 1'b0;
    end else begin
      done     <= 1'b0;
      underrun <= 1'b0;

      if (stop) begin
        state        <= ST_IDLE;
        sample_valid <= 1'b0;
        accepted     <= 1'b0;
      end else if (start) begin
        start_q      <= start_addr;
        end_q        <= end_addr;
        loop_q       <= loop;
        rom_addr     <= start_addr;
        sample_valid <= 1'b0;
        accepted     <= 1'b0;
        state        <= ST_ADDR;
      end else begin
        case (state)
          ST_IDLE: ;
          // ROM registers rom_addr on this edge; data is usable in ST_LATCH.
          ST_ADDR: state <= ST_LATCH;
          ST_LATCH: begin
            sample_out   <= rom_data;
            sample_valid <= 1'b1;
            state        <= ST_OUT;
          end
          ST_OUT: begin
            if (handshake) begin
              sample_valid <= 1'b0;
              accepted     <= 1'b1;
            end
            // NOTE: non-blocking assignments let the later clear of accepted
            // below override the set above when a handshake and a tick share
            // a cycle; the handshake still counts for this tick.
            if (tick) begin
              if (accepted || handshake) begin
                accepted <= 1'b0;
                if (rom_addr == end_q) begin
                  if (loop_q) begin
                    rom_addr <= start_q;
                    state    <= ST_ADDR;
                  end else begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                  end
                end else begin
                  rom_addr <= rom_addr + 1'b1;
                  state    <= ST_ADDR;
                end
              end else begin
                underrun <= 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
